mem_cycle_sequencer: RTL and testbench

//  Memory-cycle sequencer that sits directly upstream of the MemBridge data transceiver.
//  - Accepts single-byte read/write requests from the pipeline memory stage.
//  - Drives the memory address and chip/strobe lines, plus MemBridge_Assert/MemBridge_Direction.
//  - Owns the SETUP/STROBE/HOLD timing so that MainBus and MEMDATA never contend.
//  - Read data is captured into a register for the pipeline.

---
 rtl/mem_cycle_sequencer_pkg.sv | 22 ++
 rtl/mem_cycle_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mem_cycle_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared definitions for the memory-cycle sequencer.
//   - seqStateT : FSM state encoding (IDLE/SETUP/STROBE/HOLD)
//   - DIR_RD / DIR_WR : MemBridge_Direction levels
//   - dirFor()  : maps an access type onto the transceiver direction
package mem_cycle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seqStateT;

    // MemBridge_Direction: 1 = MEMDATA -> MainBus, 0 = MainBus -> MEMDATA
    localparam logic DIR_RD = 1'b1;
    localparam logic DIR_WR = 1'b0;

    function automatic logic dirFor(input logic isWrite);
        return isWrite ? DIR_WR : DIR_RD;
    endfunction

endpackage

// File: rtl/mem_cycle_sequencer.sv
// Memory-cycle sequencer sitting in front of the MemBridge data transceiver.
// Turns single-byte read/write requests into an IDLE -> SETUP -> STROBE
// (1+WAIT_STATES cycles) -> HOLD -> IDLE bus cycle and steers the
// transceiver so MainBus and MEMDATA never drive each other.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   Req_Valid/Write/Addr     request from the pipeline memory stage
//   Req_Ready                high only in IDLE; accept on Valid & Ready
//   Done                     one-cycle pulse during HOLD
//   MEMDATA_In               memory data pins (read capture)
//   RdData                   last captured read byte
//   MEMADDR                  registered memory address
//   MEM_CS_n/OE_n/WE_n       active-low memory strobes
//   MemBridge_Assert         transceiver enable
//   MemBridge_Direction      transceiver direction (see package)
//
// Every output is a flop. The output decode looks at the *next* state so
// the pins change on the same edge as the state register, without any
// combinational path from Req_* to the memory pins.
module mem_cycle_sequencer
    import mem_cycle_sequencer_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1,
    parameter int WS_W        = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req_Valid,
    input  logic              Req_Write,
    input  logic [ADDR_W-1:0] Req_Addr,
    output logic              Req_Ready,
    output logic              Done,
    input  logic [7:0]        MEMDATA_In,
    output logic [7:0]        RdData,
    output logic [ADDR_W-1:0] MEMADDR,
    output logic              MEM_CS_n,
    output logic              MEM_OE_n,
    output logic              MEM_WE_n,
    output logic              MemBridge_Assert,
    output logic              MemBridge_Direction
);

    seqStateT        state;
    seqStateT        nextState;
    logic            isWrite;
    logic            writeNext;
    logic [WS_W-1:0] waitCnt;
    logic            accept;
    logic            strobeLast;

    logic            readyNext;
    logic            doneNext;
    logic            csNext;
    logic            oeNext;
    logic            weNext;
    logic            assertNext;
    logic            dirNext;

    assign accept     = (state == ST_IDLE) && Req_Valid;
    assign strobeLast = (state == ST_STROBE) && (waitCnt == '0);
    // Access type as it will be during the next cycle (new request or held)
    assign writeNext  = accept ? Req_Write : isWrite;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (Req_Valid) nextState = ST_SETUP;
            ST_SETUP:  nextState = ST_STROBE;
            ST_STROBE: if (strobeLast) nextState = ST_HOLD;
            ST_HOLD:   nextState = ST_IDLE;
            default:   nextState = ST_IDLE;
        endcase
    end

    // Output decode for the coming cycle
    always_comb begin
        readyNext  = 1'b0;
        doneNext   = 1'b0;
        csNext     = 1'b1;
        oeNext     = 1'b1;
        weNext     = 1'b1;
        assertNext = 1'b0;
        // Direction only moves on IDLE -> SETUP, where Assert was low in IDLE;
        // everywhere else it simply holds.
        dirNext    = MemBridge_Direction;
        case (nextState)
            ST_IDLE: begin
                readyNext = 1'b1;
            end
            ST_SETUP: begin
                csNext     = 1'b0;
                dirNext    = dirFor(writeNext);
                // A write enables the transceiver early so MEMDATA is driven
                // before WE falls; a read keeps it off until OE has turned
                // the memory around.
                assertNext = writeNext;
            end
            ST_STROBE: begin
                csNext     = 1'b0;
                oeNext     = writeNext;
                weNext     = ~writeNext;
                assertNext = 1'b1;
            end
            ST_HOLD: begin
                csNext     = 1'b0;
                assertNext = 1'b1;
                doneNext   = 1'b1;
            end
            default: begin
                readyNext = 1'b1;
            end
        endcase
    end

    // Output, address, wait-counter and read-data registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            Req_Ready           <= 1'b1;
            Done                <= 1'b0;
            MEM_CS_n            <= 1'b1;
            MEM_OE_n            <= 1'b1;
            MEM_WE_n            <= 1'b1;
            MemBridge_Assert    <= 1'b0;
            MemBridge_Direction <= DIR_RD;
            MEMADDR             <= '0;
            RdData              <= '0;
            isWrite             <= 1'b0;
            waitCnt             <= '0;
        end else begin
            Req_Ready           <= readyNext;
            Done                <= doneNext;
            MEM_CS_n            <= csNext;
            MEM_OE_n            <= oeNext;
            MEM_WE_n            <= weNext;
            MemBridge_Assert    <= assertNext;
            MemBridge_Direction <= dirNext;

            if (accept) begin
                MEMADDR <= Req_Addr;
                isWrite <= Req_Write;
            end

            // Loaded while leaving SETUP so STROBE starts at WAIT_STATES
            if (state == ST_SETUP) begin
                waitCnt <= WS_W'(WAIT_STATES);
            end else if ((state == ST_STROBE) && (waitCnt != '0)) begin
                waitCnt <= waitCnt - WS_W'(1);
            end

            // Sample the pins at the edge that closes the last STROBE cycle,
            // while OE is still low and the data is settled.
            if (strobeLast && !isWrite) begin
                RdData <= MEMDATA_In;
            end
        end
    end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Bench for mem_cycle_sequencer: three instances (WAIT_STATES = 1, 0, 15)
// share one stimulus stream. Each instance is predicted by a timeline model
// that counts cycles since the accepted request.
module tb_mem_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqWrite;
    logic [15:0] reqAddr;
    logic [7:0]  memIn;

    logic        readyO [3];
    logic        doneO  [3];
    logic        csO    [3];
    logic        oeO    [3];
    logic        weO    [3];
    logic        asO    [3];
    logic        dirO   [3];
    logic [15:0] addrO  [3];
    logic [7:0]  rdO    [3];

    int wsOf [3] = '{1, 0, 15};

    // Reference model: ph = 0 idle, 1 setup, 2..2+ws strobe, 3+ws hold
    int          ph    [3];
    logic        mWr   [3];
    logic [15:0] mAddr [3];
    logic [7:0]  mRd   [3];
    logic        mDir  [3];

    logic        prevDir [3];
    logic        prevAs  [3];
    logic        havePrev;
    logic        rstAtEdge;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mem_cycle_sequencer #(.ADDR_W(16), .WAIT_STATES(1), .WS_W(4)) dutWs1 (
        .CLK(clk), .RST(rst), .Req_Valid(reqValid), .Req_Write(reqWrite), .Req_Addr(reqAddr),
        .Req_Ready(readyO[0]), .Done(doneO[0]), .MEMDATA_In(memIn), .RdData(rdO[0]),
        .MEMADDR(addrO[0]), .MEM_CS_n(csO[0]), .MEM_OE_n(oeO[0]), .MEM_WE_n(weO[0]),
        .MemBridge_Assert(asO[0]), .MemBridge_Direction(dirO[0]));

    mem_cycle_sequencer #(.ADDR_W(16), .WAIT_STATES(0), .WS_W(4)) dutWs0 (
        .CLK(clk), .RST(rst), .Req_Valid(reqValid), .Req_Write(reqWrite), .Req_Addr(reqAddr),
        .Req_Ready(readyO[1]), .Done(doneO[1]), .MEMDATA_In(memIn), .RdData(rdO[1]),
        .MEMADDR(addrO[1]), .MEM_CS_n(csO[1]), .MEM_OE_n(oeO[1]), .MEM_WE_n(weO[1]),
        .MemBridge_Assert(asO[1]), .MemBridge_Direction(dirO[1]));

    mem_cycle_sequencer #(.ADDR_W(16), .WAIT_STATES(15), .WS_W(4)) dutWs15 (
        .CLK(clk), .RST(rst), .Req_Valid(reqValid), .Req_Write(reqWrite), .Req_Addr(reqAddr),
        .Req_Ready(readyO[2]), .Done(doneO[2]), .MEMDATA_In(memIn), .RdData(rdO[2]),
        .MEMADDR(addrO[2]), .MEM_CS_n(csO[2]), .MEM_OE_n(oeO[2]), .MEM_WE_n(weO[2]),
        .MemBridge_Assert(asO[2]), .MemBridge_Direction(dirO[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Advance every model by one rising edge using the inputs present there
    task automatic modelEdge();
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                ph[d]    = 0;
                mAddr[d] = '0;
                mRd[d]   = '0;
                mDir[d]  = 1'b1;
            end else if (ph[d] == 0) begin
                if (reqValid) begin
                    ph[d]    = 1;
                    mWr[d]   = reqWrite;
                    mAddr[d] = reqAddr;
                    mDir[d]  = !reqWrite;
                end
            end else begin
                if (ph[d] == 2 + wsOf[d] && !mWr[d]) mRd[d] = memIn;
                ph[d] = (ph[d] == 3 + wsOf[d]) ? 0 : ph[d] + 1;
            end
        end
    endtask

    task automatic checkAll();
        for (int d = 0; d < 3; d++) begin
            logic [6:0] got;
            logic [6:0] exp;
            logic       strobe;
            int         ws;
            ws     = wsOf[d];
            strobe = (ph[d] >= 2) && (ph[d] <= 2 + ws);
            exp = {ph[d] == 0, ph[d] == 3 + ws, ph[d] == 0,
                   !(strobe && !mWr[d]), !(strobe && mWr[d]),
                   (ph[d] == 1 && mWr[d]) || (ph[d] >= 2), mDir[d]};
            got = {readyO[d], doneO[d], csO[d], oeO[d], weO[d], asO[d], dirO[d]};
            chk($sformatf("ws%0d.rdy_done_cs_oe_we_as_dir", ws), 32'(got), 32'(exp));
            chk($sformatf("ws%0d.memaddr", ws), 32'(addrO[d]), 32'(mAddr[d]));
            chk($sformatf("ws%0d.rddata", ws), 32'(rdO[d]), 32'(mRd[d]));
            // Bus-contention rules, judged on the pins alone
            chk($sformatf("ws%0d.oe_we_excl", ws), 32'(oeO[d] | weO[d]), 32'd1);
            chk($sformatf("ws%0d.we_needs_wr_bridge", ws), 32'(weO[d] | (asO[d] & ~dirO[d])), 32'd1);
            if (havePrev && !rstAtEdge)
                chk($sformatf("ws%0d.dir_change_safe", ws),
                    32'((dirO[d] == prevDir[d]) || !prevAs[d]), 32'd1);
            prevDir[d] = dirO[d];
            prevAs[d]  = asO[d];
        end
        havePrev = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        modelEdge();
        rstAtEdge = rst;
        cyc++;
        @(negedge clk);
        checkAll();
    endtask

    initial begin
        rst      = 1'b1;
        reqValid = 1'b0;
        reqWrite = 1'b0;
        reqAddr  = '0;
        memIn    = '0;
        havePrev = 1'b0;
        for (int d = 0; d < 3; d++) begin
            ph[d] = 0; mWr[d] = 1'b0; mAddr[d] = '0; mRd[d] = '0; mDir[d] = 1'b1;
        end

        // Power-on reset
        step();
        step();
        rst = 1'b0;
        step();

        // Single read
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h1234; memIn = 8'hA5;
        step();
        reqValid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("read_rddata_ws1", 32'(rdO[0]), 32'h0000_00A5);
        chk("read_memaddr_ws1", 32'(addrO[0]), 32'h0000_1234);

        // Single write
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h8001; memIn = 8'h3C;
        step();
        reqValid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("write_keeps_rddata_ws1", 32'(rdO[0]), 32'h0000_00A5);

        // Back-to-back: Valid held high, read then writes
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 16'h0F0F; memIn = 8'h5A;
        step();
        reqWrite = 1'b1; reqAddr = 16'hF0F0;
        for (int i = 0; i < 25; i++) step();
        reqValid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Reset in the middle of a write strobe on the WAIT_STATES=1 unit
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 16'h4242;
        step();
        reqValid = 1'b0;
        step();
        chk("pre_rst_we_low_ws1", 32'(weO[0]), 32'd0);
        rst = 1'b1;
        step();
        chk("rst_we_ws1", 32'(weO[0]), 32'd1);
        chk("rst_assert_ws1", 32'(asO[0]), 32'd0);
        chk("rst_cs_ws1", 32'(csO[0]), 32'd1);
        chk("rst_ready_ws1", 32'(readyO[0]), 32'd1);
        chk("rst_done_ws1", 32'(doneO[0]), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            reqValid = ($urandom_range(0, 2) != 0);
            reqWrite = 1'($urandom_range(0, 1));
            reqAddr  = 16'($urandom);
            memIn    = 8'($urandom);
            step();
        end
        rst = 1'b0; reqValid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
